// File: rtl/iobuf_bus_master.sv
// iobuf_bus_master: fabric-side controller for a bidirectional IOBUF pad bus.
// Turns single-beat read/write requests into strobe/ack cycles with setup and hi-Z turnaround.
module iobuf_bus_master #(
  parameter int WIDTH   = 8,
  parameter int SETUP   = 1,
  parameter int TURN    = 1,
  parameter int TIMEOUT = 64
) (
  input  logic             C,
  input  logic             R,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WR,
  input  logic [WIDTH-1:0] REQ_WDATA,
  output logic             RSP_VALID,
  output logic [WIDTH-1:0] RSP_RDATA,
  output logic             RSP_ERR,
  output logic [WIDTH-1:0] BUS_I,
  output logic             BUS_T,
  input  logic [WIDTH-1:0] BUS_O,
  output logic             BUS_STB,
  input  logic             BUS_ACK
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW = (TW > 4) ? TW : 4;

  localparam logic [CW-1:0] SETUP_LAST =
    CW'((SETUP > 0) ? SETUP - 1 : 0);
  localparam logic [CW-1:0] TURN_LAST =
    CW'((TURN > 0) ? TURN - 1 : 0);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_TURN,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             t_q, t_d;
  logic             stb_q, stb_d;
  logic [WIDTH-1:0] i_q, i_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rd_q, rd_d;

  assign REQ_READY = (state_q == ST_IDLE) & ~R;
  assign RSP_VALID = vld_q;
  assign RSP_RDATA = rd_q;
  assign RSP_ERR   = err_q;
  assign BUS_I     = i_q;
  assign BUS_T     = t_q;
  assign BUS_STB   = stb_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    t_d     = t_q;
    stb_d   = stb_q;
    i_d     = i_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    rd_d    = rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          cnt_d = '0;
          wr_d  = REQ_WR;
          if (REQ_WR) begin
            i_d = REQ_WDATA;
            t_d = 1'b0;
            if (SETUP == 0) begin
              state_d = ST_STROBE;
              stb_d   = 1'b1;
            end else begin
              state_d = ST_SETUP;
            end
          end else begin
            state_d = ST_STROBE;
            stb_d   = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          stb_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STROBE: begin
        // ACK is checked first so it wins over a coincident timeout
        if (BUS_ACK) begin
          state_d = ST_TURN;
          stb_d   = 1'b0;
          t_d     = 1'b1;
          err_d   = 1'b0;
          rd_d    = wr_q ? '0 : BUS_O;
          cnt_d   = '0;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d = ST_TURN;
          stb_d   = 1'b0;
          t_d     = 1'b1;
          err_d   = 1'b1;
          rd_d    = '0;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = ST_DONE;
          vld_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      t_q     <= 1'b1;
      stb_q   <= 1'b0;
      i_q     <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      t_q     <= t_d;
      stb_q   <= stb_d;
      i_q     <= i_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_iobuf_bus_master.sv
// Self-checking bench for iobuf_bus_master: vector table, corner sequences,
// and randomized transactions checked against a transaction-level model.
module tb_iobuf_bus_master;

  localparam int W  = 8;
  localparam int SU = 1;
  localparam int TU = 1;
  localparam int TO = 64;

  logic         C = 1'b0;
  logic         R;
  logic         REQ_VALID;
  logic         REQ_READY;
  logic         REQ_WR;
  logic [W-1:0] REQ_WDATA;
  logic         RSP_VALID;
  logic [W-1:0] RSP_RDATA;
  logic         RSP_ERR;
  logic [W-1:0] BUS_I;
  logic         BUS_T;
  logic [W-1:0] BUS_O;
  logic         BUS_STB;
  logic         BUS_ACK;

  iobuf_bus_master #(
    .WIDTH(W), .SETUP(SU), .TURN(TU), .TIMEOUT(TO)
  ) dut (
    .C(C), .R(R),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WR(REQ_WR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR),
    .BUS_I(BUS_I), .BUS_T(BUS_T), .BUS_O(BUS_O),
    .BUS_STB(BUS_STB), .BUS_ACK(BUS_ACK)
  );

  always #5 C = ~C;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_t0_cyc  = 0;
  int stb_start_cyc = 0;

  typedef struct {
    bit         wr;
    logic [7:0] wd;
    logic [7:0] bo;
    int         n;
    int         lat;
    bit         err;
    logic [7:0] rd;
    int         neff;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge C);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: response latency, error and data from the rules
  task automatic model(input bit wr, input logic [7:0] bo,
                       input int n, output int lat, output bit err,
                       output logic [7:0] rd, output int neff);
    bit acked;
    acked = (n >= 1) && (n <= TO);
    neff  = acked ? n : TO;
    err   = !acked;
    lat   = (wr ? SU : 0) + neff + TU;
    rd    = (wr || err) ? 8'h00 : bo;
  endtask

  // Target responds with ACK on strobe cycle n (0 = never)
  task automatic txn(input bit wr, input logic [7:0] wd,
                     input logic [7:0] bo, input int n,
                     input int elat, input bit eerr,
                     input logic [7:0] erd, input int eneff,
                     input bit hold, input bit junk,
                     input bit nwr, input logic [7:0] nwd);
    int c, sc, tcnt, fstb, guard, lat;
    bit seen, busy_ok, t_ok, i_ok, err;
    logic [7:0] rd;
    REQ_VALID = 1'b1;
    REQ_WR    = wr;
    REQ_WDATA = wd;
    BUS_O     = bo;
    BUS_ACK   = 1'b0;
    guard = 0;
    while (!REQ_READY && guard < 100) begin
      tick();
      guard++;
    end
    chk("accept_ready", REQ_READY, 1);
    tick();
    if (!hold) REQ_VALID = 1'b0;
    c = 0; sc = 0; tcnt = 0; fstb = -1; lat = -1;
    seen = 0; busy_ok = 1; t_ok = 1; i_ok = 1;
    err = 0; rd = 8'h00;
    while (c < 300) begin
      if (REQ_READY) busy_ok = 0;
      if (BUS_STB) begin
        sc++;
        if (fstb < 0) begin
          fstb = c;
          stb_start_cyc = cyc;
        end
      end
      if (!BUS_T) begin
        tcnt++;
        last_t0_cyc = cyc;
        if (!wr) t_ok = 0;
        if (BUS_I !== wd) i_ok = 0;
      end
      if (RSP_VALID) begin
        seen = 1; lat = c; err = RSP_ERR; rd = RSP_RDATA;
        break;
      end
      if (BUS_STB) BUS_ACK = (n != 0) && (sc == n);
      else BUS_ACK = junk && ($urandom_range(0, 3) == 0);
      if (junk && !hold) begin
        REQ_VALID = 1'($urandom_range(0, 1));
        REQ_WR    = 1'($urandom_range(0, 1));
        REQ_WDATA = 8'($urandom);
      end
      tick();
      c++;
    end
    BUS_ACK = 1'b0;
    if (hold) begin
      REQ_WR    = nwr;
      REQ_WDATA = nwd;
    end else begin
      REQ_VALID = 1'b0;
    end
    chk("rsp_seen", seen, 1);
    chk("rsp_latency", lat, elat);
    chk("rsp_err", err, eerr);
    if (!wr) chk("rsp_rdata", rd, erd);
    chk("stb_cycles", sc, eneff);
    chk("stb_first", fstb, wr ? SU : 0);
    chk("drive_cycles", tcnt, wr ? SU + eneff : 0);
    chk("read_hiz", t_ok, 1);
    chk("bus_i_data", i_ok, 1);
    chk("busy_not_ready", busy_ok, 1);
    tick();
    chk("rsp_one_pulse", RSP_VALID, 0);
    chk("idle_ready", REQ_READY, 1);
    chk("idle_hiz", BUS_T, 1);
  endtask

  initial begin
    int gap, lat, neff;
    bit err, wr;
    logic [7:0] rd, wd, bo;
    int n, r;
    bit stray_ok;

    tbl[0] = '{1, 8'hA5, 8'h00, 1,  3,  0, 8'h00, 1};
    tbl[1] = '{0, 8'h00, 8'h3C, 4,  5,  0, 8'h3C, 4};
    tbl[2] = '{0, 8'h00, 8'h5A, 0,  65, 1, 8'h00, 64};
    tbl[3] = '{0, 8'h00, 8'h77, 64, 65, 0, 8'h77, 64};
    tbl[4] = '{0, 8'h00, 8'h99, 65, 65, 1, 8'h00, 64};
    tbl[5] = '{1, 8'hFF, 8'h00, 3,  5,  0, 8'h00, 3};

    R = 1'b1; REQ_VALID = 1'b0; REQ_WR = 1'b0;
    REQ_WDATA = '0; BUS_O = '0; BUS_ACK = 1'b0;
    tick();
    tick();
    chk("rst_t", BUS_T, 1);
    chk("rst_stb", BUS_STB, 0);
    chk("rst_i", BUS_I, 0);
    chk("rst_vld", RSP_VALID, 0);
    chk("rst_err", RSP_ERR, 0);
    chk("rst_rdata", RSP_RDATA, 0);
    chk("rst_ready_low", REQ_READY, 0);
    R = 1'b0;
    #1;
    chk("rst_ready", REQ_READY, 1);

    // Reset in the middle of a write strobe
    REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_WDATA = 8'hC3;
    tick();
    REQ_VALID = 1'b0;
    tick();
    chk("mid_t_drive", BUS_T, 0);
    chk("mid_stb", BUS_STB, 1);
    R = 1'b1;
    tick();
    chk("abort_t", BUS_T, 1);
    chk("abort_stb", BUS_STB, 0);
    chk("abort_i", BUS_I, 0);
    chk("abort_vld", RSP_VALID, 0);
    tick();
    tick();
    R = 1'b0;
    #1;
    chk("abort_ready", REQ_READY, 1);

    // Stray ACK while idle
    stray_ok = 1;
    BUS_ACK = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (RSP_VALID || BUS_STB || !BUS_T || !REQ_READY) stray_ok = 0;
    end
    BUS_ACK = 1'b0;
    chk("idle_stray_ack", stray_ok, 1);

    for (int i = 0; i < 6; i++) begin
      txn(tbl[i].wr, tbl[i].wd, tbl[i].bo, tbl[i].n,
          tbl[i].lat, tbl[i].err, tbl[i].rd, tbl[i].neff,
          0, 0, 0, 8'h00);
    end

    // Back-to-back write then read with REQ_VALID held high
    txn(1, 8'h11, 8'h00, 2, SU + 2 + TU, 0, 8'h00, 2,
        1, 0, 0, 8'h00);
    txn(0, 8'h00, 8'hE7, 1, 1 + TU, 0, 8'hE7, 1,
        0, 0, 0, 8'h00);
    gap = stb_start_cyc - last_t0_cyc - 1;
    chk("turn_gap", (gap >= TU), 1);

    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      bo = 8'($urandom);
      r  = $urandom_range(0, 19);
      if (r == 0) n = 0;
      else if (r == 1) n = TO;
      else if (r == 2) n = TO + 1;
      else n = $urandom_range(1, 6);
      model(wr, bo, n, lat, err, rd, neff);
      txn(wr, wd, bo, n, lat, err, rd, neff, 0, 1, 0, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
